// File: rtl/issueq_int.sv
// Integer reservation station: accepts dispatched ops, wakes operands from CDB broadcasts,
// selects one ready entry per cycle. Optional macro ISSUEQ_AGE_SELECT_EN selects oldest-first.
module issueq_int #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic [3:0]        dispatch_opcode,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic              dispatch_rsvalid,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  output logic              issuequeue_full,
  input  logic [DATA_W-1:0] cdb_out,
  input  logic [TAG_W-1:0]  cdb_tagout,
  input  logic              cdb_valid,
  output logic              ready_int,
  input  logic              issue_int,
  output logic [3:0]        issue_opcode,
  output logic [DATA_W-1:0] issue_rsdata,
  output logic [DATA_W-1:0] issue_rtdata,
  output logic [TAG_W-1:0]  issue_rdtag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  rs_valid_r;
  logic [DEPTH-1:0]  rt_valid_r;
  logic [3:0]        opcode_r  [DEPTH];
  logic [DATA_W-1:0] rs_data_r [DEPTH];
  logic [DATA_W-1:0] rt_data_r [DEPTH];
  logic [TAG_W-1:0]  rs_tag_r  [DEPTH];
  logic [TAG_W-1:0]  rt_tag_r  [DEPTH];
  logic [TAG_W-1:0]  rd_tag_r  [DEPTH];
`ifdef ISSUEQ_AGE_SELECT_EN
  logic [IDX_W-1:0]  age_r     [DEPTH];
  logic [IDX_W-1:0]  best_age_s;
`endif

  logic [DEPTH-1:0]  ready_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic              dispatch_s;
  logic              grant_s;
  logic              rs_snoop_s;
  logic              rt_snoop_s;

  // Readiness uses registered state only, so nothing here sees the CDB or the grant.
  assign issuequeue_full = &valid_r;
  assign ready_s         = valid_r & rs_valid_r & rt_valid_r;
  assign ready_int       = |ready_s;
  assign dispatch_s      = dispatch_valid & ~issuequeue_full;
  assign grant_s         = issue_int & ready_int;
  assign rs_snoop_s      = ~dispatch_rsvalid & cdb_valid & (cdb_tagout == dispatch_rstag);
  assign rt_snoop_s      = ~dispatch_rtvalid & cdb_valid & (cdb_tagout == dispatch_rttag);

  assign issue_opcode = ready_int ? opcode_r[sel_idx_s]  : 4'h0;
  assign issue_rsdata = ready_int ? rs_data_r[sel_idx_s] : {DATA_W{1'b0}};
  assign issue_rtdata = ready_int ? rt_data_r[sel_idx_s] : {DATA_W{1'b0}};
  assign issue_rdtag  = ready_int ? rd_tag_r[sel_idx_s]  : {TAG_W{1'b0}};

  // Lowest-index free slot for dispatch.
  always_comb begin
    free_idx_s = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s = valid_r[i] ? free_idx_s : IDX_W'(i);
    end
  end

  // Issue selection among ready entries.
  always_comb begin
    sel_idx_s = {IDX_W{1'b0}};
`ifdef ISSUEQ_AGE_SELECT_EN
    best_age_s = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sel_idx_s  = (ready_s[i] && (age_r[i] >= best_age_s)) ? IDX_W'(i) : sel_idx_s;
      best_age_s = (ready_s[i] && (age_r[i] >= best_age_s)) ? age_r[i]  : best_age_s;
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx_s = ready_s[i] ? IDX_W'(i) : sel_idx_s;
    end
`endif
  end

  // Entry state: wakeup, release on grant, age update and dispatch write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= {DEPTH{1'b0}};
      rs_valid_r <= {DEPTH{1'b0}};
      rt_valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        opcode_r[i]  <= 4'h0;
        rs_data_r[i] <= {DATA_W{1'b0}};
        rt_data_r[i] <= {DATA_W{1'b0}};
        rs_tag_r[i]  <= {TAG_W{1'b0}};
        rt_tag_r[i]  <= {TAG_W{1'b0}};
        rd_tag_r[i]  <= {TAG_W{1'b0}};
`ifdef ISSUEQ_AGE_SELECT_EN
        age_r[i]     <= {IDX_W{1'b0}};
`endif
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && !rs_valid_r[i] && cdb_valid && (cdb_tagout == rs_tag_r[i])) begin
          rs_data_r[i]  <= cdb_out;
          rs_valid_r[i] <= 1'b1;
        end
        if (valid_r[i] && !rt_valid_r[i] && cdb_valid && (cdb_tagout == rt_tag_r[i])) begin
          rt_data_r[i]  <= cdb_out;
          rt_valid_r[i] <= 1'b1;
        end
        if (grant_s && (sel_idx_s == IDX_W'(i))) begin
          valid_r[i] <= 1'b0;
        end
`ifdef ISSUEQ_AGE_SELECT_EN
        // Younger arrivals push age up; a granted older entry pulls it back down.
        if (valid_r[i]) begin
          age_r[i] <= age_r[i] + IDX_W'(dispatch_s)
                    - IDX_W'(grant_s && (age_r[i] > age_r[sel_idx_s]));
        end
`endif
        // The free slot is invalid, so it never collides with the granted entry.
        if (dispatch_s && (free_idx_s == IDX_W'(i))) begin
          valid_r[i]    <= 1'b1;
          opcode_r[i]   <= dispatch_opcode;
          rs_tag_r[i]   <= dispatch_rstag;
          rt_tag_r[i]   <= dispatch_rttag;
          rd_tag_r[i]   <= dispatch_rdtag;
          rs_data_r[i]  <= rs_snoop_s ? cdb_out : dispatch_rsdata;
          rt_data_r[i]  <= rt_snoop_s ? cdb_out : dispatch_rtdata;
          rs_valid_r[i] <= dispatch_rsvalid | rs_snoop_s;
          rt_valid_r[i] <= dispatch_rtvalid | rt_snoop_s;
`ifdef ISSUEQ_AGE_SELECT_EN
          age_r[i]      <= {IDX_W{1'b0}};
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_issueq_int.sv
// Directed self-checking bench for issueq_int (DEPTH=4).
module tb_issueq_int;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dispatch_valid = 1'b0;
  logic [3:0]  dispatch_opcode = 4'h0;
  logic [31:0] dispatch_rsdata = 32'h0;
  logic        dispatch_rsvalid = 1'b0;
  logic [5:0]  dispatch_rstag = 6'h0;
  logic [31:0] dispatch_rtdata = 32'h0;
  logic        dispatch_rtvalid = 1'b0;
  logic [5:0]  dispatch_rttag = 6'h0;
  logic [5:0]  dispatch_rdtag = 6'h0;
  logic        issuequeue_full;
  logic [31:0] cdb_out = 32'h0;
  logic [5:0]  cdb_tagout = 6'h0;
  logic        cdb_valid = 1'b0;
  logic        ready_int;
  logic        issue_int = 1'b0;
  logic [3:0]  issue_opcode;
  logic [31:0] issue_rsdata;
  logic [31:0] issue_rtdata;
  logic [5:0]  issue_rdtag;

  int total = 0;
  int bad = 0;

  issueq_int #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_rsdata(dispatch_rsdata), .dispatch_rsvalid(dispatch_rsvalid),
    .dispatch_rstag(dispatch_rstag), .dispatch_rtdata(dispatch_rtdata),
    .dispatch_rtvalid(dispatch_rtvalid), .dispatch_rttag(dispatch_rttag),
    .dispatch_rdtag(dispatch_rdtag), .issuequeue_full(issuequeue_full),
    .cdb_out(cdb_out), .cdb_tagout(cdb_tagout), .cdb_valid(cdb_valid),
    .ready_int(ready_int), .issue_int(issue_int), .issue_opcode(issue_opcode),
    .issue_rsdata(issue_rsdata), .issue_rtdata(issue_rtdata), .issue_rdtag(issue_rdtag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    issue_int      = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] rsd, input logic rsv,
                      input logic [5:0] rst, input logic [31:0] rtd, input logic rtv,
                      input logic [5:0] rtt, input logic [5:0] rd);
    dispatch_valid   = 1'b1;
    dispatch_opcode  = op;
    dispatch_rsdata  = rsd;
    dispatch_rsvalid = rsv;
    dispatch_rstag   = rst;
    dispatch_rtdata  = rtd;
    dispatch_rtvalid = rtv;
    dispatch_rttag   = rtt;
    dispatch_rdtag   = rd;
  endtask

  task automatic bcast(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid  = 1'b1;
    cdb_tagout = tag;
    cdb_out    = data;
  endtask

  initial begin
    // reset
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 64'(ready_int), 64'd0);
    chk("rst_full", 64'(issuequeue_full), 64'd0);
    chk("rst_outs", {issue_opcode, issue_rsdata, issue_rdtag}, 64'd0);

    // ready op, issue
    disp(4'h2, 32'd5, 1'b1, 6'h00, 32'd7, 1'b1, 6'h00, 6'h11);
    tick(); idle();
    chk("t1_ready", 64'(ready_int), 64'd1);
    chk("t1_rs", 64'(issue_rsdata), 64'd5);
    chk("t1_rt", 64'(issue_rtdata), 64'd7);
    chk("t1_rd", 64'(issue_rdtag), 64'h11);
    chk("t1_op", 64'(issue_opcode), 64'h2);
    issue_int = 1'b1;
    tick(); idle();
    chk("t1_freed", 64'(ready_int), 64'd0);
    chk("t1_idle_rd", 64'(issue_rdtag), 64'd0);

    // rs pending, woken by a later broadcast
    disp(4'h3, 32'h0, 1'b0, 6'h09, 32'd1, 1'b1, 6'h00, 6'h12);
    tick(); idle();
    chk("t2_pend", 64'(ready_int), 64'd0);
    tick(); tick();
    bcast(6'h09, 32'hDEAD);
    #1;
    chk("t2_bcast_cycle", 64'(ready_int), 64'd0);
    tick(); idle();
    chk("t2_woken", 64'(ready_int), 64'd1);
    chk("t2_rs", 64'(issue_rsdata), 64'hDEAD);
    chk("t2_rt", 64'(issue_rtdata), 64'd1);
    issue_int = 1'b1;
    tick(); idle();
    chk("t2_freed", 64'(ready_int), 64'd0);

    // dispatch-cycle snoop on rt
    disp(4'h4, 32'd3, 1'b1, 6'h00, 32'h0, 1'b0, 6'h0A, 6'h13);
    bcast(6'h0A, 32'h1234);
    tick(); idle();
    chk("t3_ready", 64'(ready_int), 64'd1);
    chk("t3_rt", 64'(issue_rtdata), 64'h1234);
    chk("t3_rs", 64'(issue_rsdata), 64'd3);
    issue_int = 1'b1;
    tick(); idle();
    chk("t3_freed", 64'(ready_int), 64'd0);

    // fill with unready ops
    for (int k = 0; k < 4; k++) begin
      disp(4'h5, 32'h0, 1'b0, 6'(6'h20 + k), 32'd9, 1'b1, 6'h00, 6'(6'h30 + k));
      tick();
    end
    idle();
    chk("t4_full", 64'(issuequeue_full), 64'd1);
    chk("t4_none_ready", 64'(ready_int), 64'd0);
    disp(4'h6, 32'd1, 1'b1, 6'h00, 32'd2, 1'b1, 6'h00, 6'h3F);
    tick(); idle();
    chk("t4_drop_ready", 64'(ready_int), 64'd0);
    chk("t4_drop_full", 64'(issuequeue_full), 64'd1);
    bcast(6'h22, 32'h22);
    tick(); idle();
    chk("t4_wake_ready", 64'(ready_int), 64'd1);
    chk("t4_wake_rd", 64'(issue_rdtag), 64'h32);
    chk("t4_wake_rs", 64'(issue_rsdata), 64'h22);
    issue_int = 1'b1;
    #1;
    chk("t4_full_in_grant", 64'(issuequeue_full), 64'd1);
    tick(); idle();
    chk("t4_full_after", 64'(issuequeue_full), 64'd0);
    chk("t4_ready_after", 64'(ready_int), 64'd0);

    // hold without grant, later wake of a higher index must not steal selection
    bcast(6'h20, 32'hA0);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) bcast(6'h21, 32'hA1);
      tick(); idle();
      chk("t5_hold_ready", 64'(ready_int), 64'd1);
      chk("t5_hold_rd", 64'(issue_rdtag), 64'h30);
      chk("t5_hold_rs", 64'(issue_rsdata), 64'hA0);
    end
    chk("t5_not_full", 64'(issuequeue_full), 64'd0);

    // reset with entries pending beats a simultaneous dispatch
    reset = 1'b1;
    disp(4'h7, 32'd1, 1'b1, 6'h00, 32'd2, 1'b1, 6'h00, 6'h15);
    tick(); idle();
    reset = 1'b0;
    chk("t6_ready", 64'(ready_int), 64'd0);
    chk("t6_full", 64'(issuequeue_full), 64'd0);
    chk("t6_outs", {issue_opcode, issue_rtdata, issue_rdtag}, 64'd0);

    // selection order after a slot is recycled
    disp(4'h1, 32'd1, 1'b1, 6'h00, 32'd1, 1'b1, 6'h00, 6'h0A);
    tick();
    disp(4'h1, 32'd2, 1'b1, 6'h00, 32'd2, 1'b1, 6'h00, 6'h0B);
    issue_int = 1'b1;
    tick(); idle();
    chk("t7_b_only", 64'(issue_rdtag), 64'h0B);
    disp(4'h1, 32'd3, 1'b1, 6'h00, 32'd3, 1'b1, 6'h00, 6'h0C);
    tick(); idle();
`ifdef ISSUEQ_AGE_SELECT_EN
    chk("t7_first", 64'(issue_rdtag), 64'h0B);
    issue_int = 1'b1;
    tick(); idle();
    chk("t7_second", 64'(issue_rdtag), 64'h0C);
`else
    chk("t7_first", 64'(issue_rdtag), 64'h0C);
    issue_int = 1'b1;
    tick(); idle();
    chk("t7_second", 64'(issue_rdtag), 64'h0B);
`endif
    issue_int = 1'b1;
    tick(); idle();
    chk("t7_empty", 64'(ready_int), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
